// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC and assembles a 32-bit little-endian instruction
// from a byte-wide synchronous ROM, then offers it downstream with a valid/ready handshake.
module instr_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [7:0]            mem_rdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           instr,
  output logic [6:0]            op,
  output logic [2:0]            funct3,
  output logic                  funct7_5,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  PCSrc,
  input  logic [31:0]           ImmExt
);

  typedef enum logic [1:0] {IDLE, REQ, CAP, VALID} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              cnt_reg;
  logic [ADDR_WIDTH-1:0]   pc_reg;
  logic [ADDR_WIDTH-1:0]   pc_next;
  logic [31:0]             instr_reg;
  logic                    accept;

  assign accept = (state_reg == VALID) && instr_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = REQ;
      REQ:     state_next = CAP;
      CAP:     state_next = (cnt_reg == 2'd3) ? VALID : REQ;
      VALID:   state_next = instr_ready ? REQ : VALID;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_addr    = pc_reg;
    instr_valid = 1'b0;
    case (state_reg)
      REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = pc_reg + ADDR_WIDTH'(cnt_reg);
      end
      VALID:   instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Branch target or sequential PC, always word aligned
  always_comb begin
    pc_next = PCSrc ? (pc_reg + ImmExt[ADDR_WIDTH-1:0]) : (pc_reg + ADDR_WIDTH'(4));
    pc_next = pc_next & ~ADDR_WIDTH'(3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 2'd0;
      pc_reg  <= RESET_PC;
    end else begin
      if (state_reg == CAP) cnt_reg <= cnt_reg + 2'd1;
      if (accept)           pc_reg  <= pc_next;
    end
  end

  // One capture register per instruction byte, enabled by the byte index
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          instr_reg[8*gi +: 8] <= 8'h00;
        else if ((state_reg == CAP) && (cnt_reg == 2'(gi)))
          instr_reg[8*gi +: 8] <= mem_rdata;
      end
    end
  endgenerate

  assign pc       = pc_reg;
  assign instr    = instr_reg;
  assign op       = instr_reg[6:0];
  assign funct3   = instr_reg[14:12];
  assign funct7_5 = instr_reg[30];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch timing, sequential/branch PC update,
// backpressure, PC wrap-around and reset during a fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, rst_w;
  logic [31:0] mem_addr, mem_addr_w;
  logic        mem_rd_en, mem_rd_en_w;
  logic [7:0]  mem_rdata, mem_rdata_w;
  logic [31:0] pc, pc_w, instr, instr_w;
  logic [6:0]  op, op_w;
  logic [2:0]  funct3, funct3_w;
  logic        funct7_5, funct7_5_w;
  logic        instr_valid, instr_valid_w;
  logic        instr_ready, instr_ready_w;
  logic        pcsrc, pcsrc_w;
  logic [31:0] imm, imm_w;

  logic [7:0]  rom [0:63];
  logic [31:0] addr_q[$];
  logic [31:0] addr_w_q[$];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .pc(pc), .instr(instr), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .PCSrc(pcsrc), .ImmExt(imm)
  );

  instr_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .mem_addr(mem_addr_w), .mem_rd_en(mem_rd_en_w), .mem_rdata(mem_rdata_w),
    .pc(pc_w), .instr(instr_w), .op(op_w), .funct3(funct3_w), .funct7_5(funct7_5_w),
    .instr_valid(instr_valid_w), .instr_ready(instr_ready_w), .PCSrc(pcsrc_w), .ImmExt(imm_w)
  );

  // Synchronous byte ROMs plus read-address logs
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= rom[mem_addr[5:0]];
      addr_q.push_back(mem_addr);
    end
    if (mem_rd_en_w) begin
      mem_rdata_w <= rom[mem_addr_w[5:0]];
      addr_w_q.push_back(mem_addr_w);
    end
  end

  task automatic put_word(input int a, input logic [31:0] w);
    rom[a]   = w[7:0];
    rom[a+1] = w[15:8];
    rom[a+2] = w[23:16];
    rom[a+3] = w[31:24];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until instr_valid is seen, or -1 on timeout
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (instr_valid) break;
    end
    if (!instr_valid) n = -1;
  endtask

  task automatic test_reset();
    #2;
    vecs++;
    if (instr_valid !== 1'b0 || mem_rd_en !== 1'b0 || pc !== 32'h0 || mem_addr !== 32'h0 ||
        instr !== 32'h0 || op !== 7'h0 || funct3 !== 3'h0 || funct7_5 !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: valid=%0b rd_en=%0b pc=%h addr=%h instr=%h, required 0/0/0/0/0",
               instr_valid, mem_rd_en, pc, mem_addr, instr);
    end
    vecs++;
    if (pc_w !== 32'hFFFF_FFFC || mem_addr_w !== 32'hFFFF_FFFC || instr_valid_w !== 1'b0) begin
      errs++;
      $display("FAIL reset_pc_param: pc=%h addr=%h valid=%0b, required fffffffc/fffffffc/0",
               pc_w, mem_addr_w, instr_valid_w);
    end
  endtask

  task automatic test_first_fetch();
    int n;
    @(posedge clk);
    #1;
    addr_q.delete();
    rst = 1'b0;
    wait_valid(n);
    vecs++;
    if (n !== 9) begin
      errs++;
      $display("FAIL first_latency: valid after %0d edges, required 9", n);
    end
    vecs++;
    if (instr !== 32'h0050_0093 || op !== 7'h13 || funct3 !== 3'h0 || pc !== 32'h0) begin
      errs++;
      $display("FAIL first_instr: instr=%h op=%h f3=%h pc=%h, required 00500093/13/0/0",
               instr, op, funct3, pc);
    end
    vecs++;
    if (addr_q.size() != 4 || addr_q[0] !== 32'h0 || addr_q[1] !== 32'h1 ||
        addr_q[2] !== 32'h2 || addr_q[3] !== 32'h3) begin
      errs++;
      $display("FAIL first_addrs: %0d reads, first=%h, required 4 reads at 0..3",
               addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'hx);
    end
  endtask

  task automatic test_sequential();
    int n;
    logic [31:0] exp_pc [2];
    logic [31:0] exp_in [2];
    exp_pc[0] = 32'h4; exp_in[0] = 32'h00A0_0113;
    exp_pc[1] = 32'h8; exp_in[1] = 32'h0020_81B3;
    pcsrc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++;
      if (instr_valid !== 1'b0 || pc !== exp_pc[i]) begin
        errs++;
        $display("FAIL seq_accept%0d: valid=%0b pc=%h, required 0/%h", i, instr_valid, pc, exp_pc[i]);
      end
      wait_valid(n);
      vecs++;
      if (n !== 8 || instr !== exp_in[i]) begin
        errs++;
        $display("FAIL seq_fetch%0d: edges=%0d instr=%h, required 8/%h", i, n, instr, exp_in[i]);
      end
    end
    vecs++;
    if (op !== 7'h33 || funct7_5 !== 1'b0) begin
      errs++;
      $display("FAIL seq_fields: op=%h f7_5=%0b, required 33/0", op, funct7_5);
    end
  endtask

  task automatic test_branch();
    int n;
    // pc 0x8 + 6 -> 0xE, low bits cleared -> 0xC
    pcsrc = 1'b1; imm = 32'h0000_0006;
    step();
    pcsrc = 1'b0; imm = 32'h0;
    vecs++;
    if (pc !== 32'hC) begin
      errs++;
      $display("FAIL branch_plus6: pc=%h, required c", pc);
    end
    wait_valid(n);
    vecs++;
    if (n !== 8 || instr !== 32'h4020_8233 || funct7_5 !== 1'b1 || op !== 7'h33) begin
      errs++;
      $display("FAIL branch_fetch_c: edges=%0d instr=%h f7_5=%0b, required 8/40208233/1", n, instr, funct7_5);
    end
    pcsrc = 1'b1; imm = 32'hFFFF_FFFC;
    step();
    pcsrc = 1'b0;
    wait_valid(n);
    vecs++;
    if (pc !== 32'h8 || n !== 8) begin
      errs++;
      $display("FAIL branch_minus4: pc=%h edges=%0d, required 8/8", pc, n);
    end
    pcsrc = 1'b1; imm = 32'hFFFF_FFF8;
    step();
    pcsrc = 1'b0; imm = 32'h0;
    instr_ready = 1'b0;
    vecs++;
    if (pc !== 32'h0 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL branch_minus8: pc=%h valid=%0b, required 0/0", pc, instr_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    wait_valid(n);
    addr_q.delete();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      pcsrc = ~pcsrc;
      imm = 32'h100;
      step();
      if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h0050_0093 ||
          mem_rd_en !== 1'b0 || mem_addr !== 32'h0) bad++;
    end
    vecs++;
    if (bad != 0 || addr_q.size() != 0) begin
      errs++;
      $display("FAIL backpressure: %0d unstable cycles, %0d reads, required 0/0", bad, addr_q.size());
    end
    pcsrc = 1'b0; imm = 32'h0; instr_ready = 1'b1;
    step();
    vecs++;
    if (pc !== 32'h4 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL backpressure_release: pc=%h valid=%0b, required 4/0", pc, instr_valid);
    end
  endtask

  task automatic test_reset_midfetch();
    int n;
    wait_valid(n);
    pcsrc = 1'b1; imm = 32'h0000_000C;
    step();
    pcsrc = 1'b0; imm = 32'h0;
    vecs++;
    if (pc !== 32'h10) begin
      errs++;
      $display("FAIL midfetch_pc: pc=%h, required 10", pc);
    end
    for (int i = 0; i < 5; i++) step();
    // CAP cycle for byte 2: bytes 0,1 of 0x0000A283 over the old 0x00A00113
    vecs++;
    if (instr !== 32'h00A0_A283 || mem_rd_en !== 1'b0) begin
      errs++;
      $display("FAIL midfetch_partial: instr=%h rd_en=%0b, required 00a0a283/0", instr, mem_rd_en);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || mem_addr !== 32'h0) begin
      errs++;
      $display("FAIL midfetch_abort: valid=%0b pc=%h instr=%h addr=%h, required 0/0/0/0",
               instr_valid, pc, instr, mem_addr);
    end
    @(posedge clk);
    #1;
    addr_q.delete();
    rst = 1'b0;
    wait_valid(n);
    vecs++;
    if (n !== 9 || pc !== 32'h0 || instr !== 32'h0050_0093 || addr_q.size() != 4 ||
        addr_q[0] !== 32'h0 || addr_q[3] !== 32'h3) begin
      errs++;
      $display("FAIL midfetch_restart: edges=%0d pc=%h instr=%h reads=%0d, required 9/0/00500093/4",
               n, pc, instr, addr_q.size());
    end
  endtask

  task automatic test_wrap();
    int n;
    @(posedge clk);
    #1;
    addr_w_q.delete();
    rst_w = 1'b0;
    n = 0;
    while (n < 40 && !instr_valid_w) begin step(); n++; end
    vecs++;
    if (n !== 9 || pc_w !== 32'hFFFF_FFFC || instr_w !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL wrap_fetch: edges=%0d pc=%h instr=%h, required 9/fffffffc/deadbeef", n, pc_w, instr_w);
    end
    vecs++;
    if (addr_w_q.size() != 4 || addr_w_q[0] !== 32'hFFFF_FFFC || addr_w_q[1] !== 32'hFFFF_FFFD ||
        addr_w_q[2] !== 32'hFFFF_FFFE || addr_w_q[3] !== 32'hFFFF_FFFF) begin
      errs++;
      $display("FAIL wrap_addrs: %0d reads, first=%h, required 4 reads fffffffc..ffffffff",
               addr_w_q.size(), (addr_w_q.size() > 0) ? addr_w_q[0] : 32'hx);
    end
    addr_w_q.delete();
    step();
    vecs++;
    if (pc_w !== 32'h0) begin
      errs++;
      $display("FAIL wrap_pc: pc=%h, required 0", pc_w);
    end
    n = 0;
    while (n < 40 && !instr_valid_w) begin step(); n++; end
    vecs++;
    if (n !== 8 || instr_w !== 32'h0050_0093 || addr_w_q.size() != 4 || addr_w_q[0] !== 32'h0 ||
        addr_w_q[1] !== 32'h1 || addr_w_q[2] !== 32'h2 || addr_w_q[3] !== 32'h3) begin
      errs++;
      $display("FAIL wrap_refetch: edges=%0d instr=%h reads=%0d, required 8/00500093/4 at 0..3",
               n, instr_w, addr_w_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    put_word(0,  32'h0050_0093);
    put_word(4,  32'h00A0_0113);
    put_word(8,  32'h0020_81B3);
    put_word(12, 32'h4020_8233);
    put_word(16, 32'h0000_A283);
    put_word(60, 32'hDEAD_BEEF);
    rst = 1'b1; rst_w = 1'b1;
    instr_ready = 1'b1; pcsrc = 1'b0; imm = 32'h0;
    instr_ready_w = 1'b1; pcsrc_w = 1'b0; imm_w = 32'h0;

    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_backpressure();
    test_reset_midfetch();
    test_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle RISC-V core; sits directly upstream of the control unit and decode logic. It holds the program counter, assembles each 32-bit instruction little-endian from a byte-wide synchronous instruction ROM over four read/capture pairs, and presents the instruction plus its `op`/`funct3`/`funct7_5` fields with a valid/ready handshake. On acceptance it advances the PC to PC+4 or to the branch target, using the downstream `PCSrc` and `ImmExt`.

## Interface
- `ADDR_WIDTH`, 32: PC and ROM address width.
- `RESET_PC`, 0: PC value loaded on reset. Must be a multiple of 4.

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_addr`  out  ADDR_WIDTH  ROM byte address.
- `mem_rd_en`  out  1  ROM read strobe.
- `mem_rdata`  in  8  ROM data, valid one cycle after a strobed address.
- `pc`  out  ADDR_WIDTH  address of the current instruction.
- `instr`  out  32  assembled instruction.
- `op`  out  7  `instr[6:0]`.
- `funct3`  out  3  `instr[14:12]`.
- `funct7_5`  out  1  `instr[30]`.
- `instr_valid`  out  1  `instr` is complete and stable.
- `instr_ready`  in  1  downstream accepts the instruction this cycle.
- `PCSrc`  in  1  branch taken, from the control unit.
- `ImmExt`  in  32  sign-extended branch offset.

## Operation
- FSM states:
  - `IDLE`: reset state only. Moves to `REQ` on the next edge.
  - `REQ`: drives `mem_addr = pc + cnt` with `mem_rd_en = 1`. Moves to `CAP`.
  - `CAP`: `instr[8*cnt+7 : 8*cnt] <= mem_rdata`. If `cnt == 3`, clear `cnt` and go to `VALID`; otherwise increment `cnt` and go to `REQ`.
  - `VALID`: `instr_valid = 1`.
- `cnt` is a 2-bit byte index. Bytes are little-endian: byte 0 comes from `pc`, byte 3 from `pc+3`.
- In `VALID`, `instr_ready` low holds the state. `pc`, `instr` and the field outputs stay stable.
- Accept is `VALID & instr_ready` at a rising edge. On accept:
  - `pc <= PCSrc ? pc + ImmExt[ADDR_WIDTH-1:0] : pc + 4`.
  - Bits `[1:0]` of the new PC are forced to 0.
  - State goes to `REQ`.
- `PCSrc` and `ImmExt` are sampled only on the accept edge and ignored in all other states.
- `instr_ready` is ignored outside `VALID`.
- Arithmetic is modulo 2^ADDR_WIDTH. PC wraps silently and no fault is flagged.
- Outside `REQ`: `mem_rd_en = 0` and `mem_addr` holds `pc`.
- `instr` is not cleared between fetches. Bytes are overwritten in order.
- `op`, `funct3` and `funct7_5` are purely combinational slices of `instr`.

## Timing
- Reset values (applied asynchronously):
  - state `IDLE`, `cnt = 0`, `pc = RESET_PC`, `instr = 0`.
  - `instr_valid = 0`, `mem_rd_en = 0`, `mem_addr = RESET_PC`.
  - `op = 0`, `funct3 = 0`, `funct7_5 = 0`.
- After reset release:
  - edge 1: `IDLE -> REQ`.
  - edges 2–9: REQ/CAP ×4.
  - `instr_valid` is first high in the cycle after edge 9.
- Fetch latency is 8 cycles from entering `REQ` to `instr_valid` high. With `instr_ready` held high, throughput is one instruction per 9 cycles (8 fetch + 1 `VALID`).
- `mem_rd_en` is high in cycles 0, 2, 4 and 6 of a fetch, with addresses `pc`, `pc+1`, `pc+2`, `pc+3`. `mem_rdata` is captured in cycles 1, 3, 5 and 7.
- `instr_valid` drops in the cycle after the accept edge. The new `pc` is visible in that same cycle.
- Reset asserted mid-fetch or in `VALID` aborts immediately. The partial instruction is discarded and the reset values apply; no accept is recorded.

## Test plan
- Reset, then ROM holds 0x00500093 at 0x0 (LSB first) with `instr_ready = 1`:
  - `instr_valid` first rises 9 cycles after reset release.
  - `instr = 0x00500093`, `op = 0x13`, `funct3 = 0`, `pc = 0`.
  - `mem_rd_en` pulses at addresses 0, 1, 2, 3.
- Sequential fetch with `PCSrc = 0`: three accepted instructions show `pc` = 0x0, 0x4, 0x8. `instr_valid` is high once every 9 cycles.
- Branch: at `pc = 0x8`, accept with `PCSrc = 1`, `ImmExt = 0xFFFFFFF8` → next `pc = 0x0`. With `ImmExt = 0x6` → `pc = 0xC` (low bits forced to 0).
- Backpressure: hold `instr_ready = 0` for 20 cycles in `VALID`:
  - `instr`, `pc` and `instr_valid` stay stable, and `mem_rd_en` stays 0.
  - Toggling `PCSrc` meanwhile has no effect.
- Wrap-around: `RESET_PC = 0xFFFFFFFC`, accept with `PCSrc = 0` → `pc = 0x0`. Fetch addresses are 0xFFFFFFFC–0xFFFFFFFF, then 0x0–0x3.
- Reset mid-fetch: assert `rst` in the CAP cycle for byte 2 at `pc = 0x10`:
  - `instr_valid = 0`, `pc = RESET_PC` and `instr = 0` immediately.
  - The next fetch restarts from `RESET_PC` byte 0.
